// File: rtl/node_fanout_tx.sv
// Single-input, multi-destination transmit buffer: each stored word carries a port mask
// and retires only after every masked neighbour port has taken it.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_EMPTY   | no words held, out_valid all low
// ST_PARTIAL | at least one word held, room for more
// ST_FULL    | DEPTH words held, in_ready low
module node_fanout_tx #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int NDEST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [NDEST-1:0]           in_dest,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [NDEST-1:0]           out_valid,
    input  logic [NDEST-1:0]           out_ready,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [7:0]                 drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } status_t;

    status_t          state;
    status_t          state_next;

    logic [WIDTH-1:0] mem_data [DEPTH];
    logic [NDEST-1:0] mem_mask [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [OW-1:0]    occ_q;
    logic [7:0]       drop_q;
    logic [NDEST-1:0] sent;

    logic             empty;
    logic             push;
    logic             store;
    logic             drop;
    logic             retire;
    logic [NDEST-1:0] head_mask;
    logic [NDEST-1:0] hs;

    assign empty     = (state == ST_EMPTY);
    assign in_ready  = !rst && (state != ST_FULL);
    assign push      = in_valid && in_ready;
    assign store     = push && (in_dest != '0);
    assign drop      = push && (in_dest == '0);
    assign head_mask = mem_mask[rd_ptr];

    // Outputs are forced to their idle values for the whole reset window.
    assign out_valid = (rst || empty) ? '0 : (head_mask & ~sent);
    assign out_data  = (rst || empty) ? '0 : mem_data[rd_ptr];
    assign occupancy = rst ? '0 : occ_q;
    assign drop_cnt  = rst ? '0 : drop_q;

    assign hs     = out_valid & out_ready;
    assign retire = !rst && !empty && ((sent | hs) == head_mask);

    always_ff @(posedge clk) begin
        if (store) begin
            mem_data[wr_ptr] <= in_data;
            mem_mask[wr_ptr] <= in_dest;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_EMPTY;
            occ_q  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            sent   <= '0;
            drop_q <= '0;
        end else begin
            state <= state_next;
            if (store) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (retire) begin
                rd_ptr <= rd_ptr + 1'b1;
                sent   <= '0;
            end else begin
                sent <= sent | hs;
            end
            case ({store, retire})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
            if (drop && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        if (store && !retire) begin
            state_next = (occ_q == OW'(DEPTH - 1)) ? ST_FULL : ST_PARTIAL;
        end else if (retire && !store) begin
            state_next = (occ_q == OW'(1)) ? ST_EMPTY : ST_PARTIAL;
        end
    end

endmodule
